branch_target_predictor: RTL and testbench
==========================================

# branch_target_predictor

Parametrised, direct-mapped branch target buffer with saturating direction counters. It replaces the fetch-stage next-PC lookup table of the 4-stage pipelined CPU. Fetch gets a combinational next-PC prediction for the current PC. The branch-resolution stage trains the table one cycle later and reports mispredictions, which the block tallies.

## Interface
- DBITS, 32, PC/target width
- INSTSIZE, 4, byte increment for fall-through PC
- IDXBITS, 8, index width; table depth = 2^IDXBITS entries
- TAGBITS, 8, stored tag width (>=1)
- CNTBITS, 2, direction counter width (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- lk_pc  in  DBITS  fetch PC to predict
- lk_hit  out  1  valid entry with matching tag
- lk_taken  out  1  prediction is taken
- lk_predpc  out  DBITS  predicted next PC
- up_valid  in  1  resolved branch update this cycle
- up_pc  in  DBITS  PC of the resolved branch instruction
- up_taken  in  1  actual direction
- up_target  in  DBITS  actual taken target
- up_mispred  in  1  resolution stage detected misprediction
- flush  in  1  invalidate whole table
- upd_cnt  out  DBITS  count of accepted updates
- mispred_cnt  out  DBITS  count of reported mispredictions

## Operation
- Address split: index = pc[IDXBITS+1:2]; tag = pc[IDXBITS+TAGBITS+1:IDXBITS+2]. pc[1:0] is ignored.
- Entry fields: valid, tag, target[DBITS], ctr[CNTBITS].
- Lookup is combinational:
  - lk_hit = valid & tag match.
  - lk_taken = lk_hit & ctr MSB.
  - lk_predpc = lk_taken ? target : lk_pc + INSTSIZE, computed modulo 2^DBITS.
- Update is applied on posedge clk when up_valid is high. Entry hit is evaluated at up_pc.
  - Taken, hit: ctr saturating +1 (max 2^CNTBITS-1); target <= up_target.
  - Taken, miss (invalid or tag differs): allocate. valid<=1, tag<=up tag, target<=up_target, ctr<=2^(CNTBITS-1) (weakly taken). Replaces any aliased entry.
  - Not taken, hit: ctr saturating -1 (min 0); entry stays valid.
  - Not taken, miss: table unchanged.
- flush: on the next posedge all valid bits clear. Counters and targets are unchanged.
  - flush and up_valid in the same cycle: flush wins and the update is dropped.
  - upd_cnt does not increment in that cycle.
  - mispred_cnt still counts.
- upd_cnt increments on each applied update and wraps at 2^DBITS.
- mispred_cnt increments when up_valid & up_mispred and wraps.
- Reset, asynchronous:
  - All valid bits go to 0.
  - All ctr go to 2^(CNTBITS-1)-1 (weakly not taken).
  - All targets go to 0.
  - upd_cnt and mispred_cnt go to 0.
  - Outputs therefore read lk_hit=0, lk_taken=0, lk_predpc=lk_pc+INSTSIZE.
  - Reset mid-operation discards any in-flight update.

## Timing
- Lookup latency is 0 cycles, combinational from lk_pc and table state.
- Update latency is 1 cycle: the change is visible to lookups starting the cycle after the update edge.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update contents. There is no bypass.
- Table state (valid, tag, ctr, target) and the counters are flops with async reset, so there is no reset sweep and no ready signal. The block is usable on the first edge after reset deasserts.

## Test plan
- Reset, then lk_pc=0x100 -> lk_hit=0, lk_taken=0, lk_predpc=0x104; upd_cnt=0, mispred_cnt=0.
- Update up_pc=0x100, taken, up_target=0x200, up_mispred=1 -> next cycle lk_pc=0x100 gives hit=1, taken=1, predpc=0x200 (ctr=2); upd_cnt=1, mispred_cnt=1.
- Hysteresis and saturation:
  - Two not-taken updates at 0x100 -> ctr 1 then 0; predpc=0x104 while hit=1.
  - Four taken updates -> ctr 1,2,3,3; predpc=0x200.
- Aliasing: 0x100 and 0x500 share index 0x40 with different tags.
  - lk_pc=0x500 misses.
  - Not-taken update at 0x500 leaves the 0x100 entry intact.
  - Taken update at 0x500 with target 0x600 -> 0x500 predicts 0x600, 0x100 now misses.
- Same-cycle events:
  - Lookup 0x100 during a taken update to 0x100 with a new target 0x300 -> the old target is returned, and 0x300 is returned the next cycle.
  - flush+up_valid+up_mispred -> all lookups miss next cycle, upd_cnt unchanged, mispred_cnt +1.
- Assert reset asynchronously between edges with entries valid -> lk_hit drops to 0 immediately and both counters read 0. After release, the first lookup of 0x100 misses.

Source files
------------

// File: rtl/branch_target_predictor_if.sv
// rtl/branch_target_predictor_if.sv - fetch lookup, resolution update and statistics signals of the BTB
interface branch_target_predictor_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] lk_pc;
    logic             lk_hit;
    logic             lk_taken;
    logic [DBITS-1:0] lk_predpc;
    logic             up_valid;
    logic [DBITS-1:0] up_pc;
    logic             up_taken;
    logic [DBITS-1:0] up_target;
    logic             up_mispred;
    logic             flush;
    logic [DBITS-1:0] upd_cnt;
    logic [DBITS-1:0] mispred_cnt;

    modport master (
        output lk_pc,
        input  lk_hit, lk_taken, lk_predpc,
        output up_valid, up_pc, up_taken, up_target, up_mispred, flush,
        input  upd_cnt, mispred_cnt
    );

    modport slave (
        input  lk_pc,
        output lk_hit, lk_taken, lk_predpc,
        input  up_valid, up_pc, up_taken, up_target, up_mispred, flush,
        output upd_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped branch target buffer with saturating direction counters
module branch_target_predictor #(
    parameter int DBITS    = 32,
    parameter int INSTSIZE = 4,
    parameter int IDXBITS  = 8,
    parameter int TAGBITS  = 8,
    parameter int CNTBITS  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    branch_target_predictor_if.slave   bus
);
    localparam int DEPTH = 1 << IDXBITS;
    localparam logic [CNTBITS-1:0] CTR_WNT = CNTBITS'((1 << (CNTBITS - 1)) - 1);
    localparam logic [CNTBITS-1:0] CTR_WT  = CNTBITS'(1 << (CNTBITS - 1));
    localparam logic [CNTBITS-1:0] CTR_MAX = {CNTBITS{1'b1}};

    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [TAGBITS-1:0] tag_q    [DEPTH];
    logic [TAGBITS-1:0] tag_d    [DEPTH];
    logic [DBITS-1:0]   target_q [DEPTH];
    logic [DBITS-1:0]   target_d [DEPTH];
    logic [CNTBITS-1:0] ctr_q    [DEPTH];
    logic [CNTBITS-1:0] ctr_d    [DEPTH];
    logic [DBITS-1:0]   upd_cnt_q, upd_cnt_d;
    logic [DBITS-1:0]   mispred_cnt_q, mispred_cnt_d;

    logic [IDXBITS-1:0] lk_idx, up_idx;
    logic [TAGBITS-1:0] lk_tag, up_tag;
    logic               lk_hit, lk_taken, up_hit;

    assign lk_idx = bus.lk_pc[IDXBITS+1:2];
    assign lk_tag = bus.lk_pc[IDXBITS+TAGBITS+1:IDXBITS+2];
    assign up_idx = bus.up_pc[IDXBITS+1:2];
    assign up_tag = bus.up_pc[IDXBITS+TAGBITS+1:IDXBITS+2];

    // Byte offset and PC bits above the tag take no part in indexing or matching.
    logic unused_up_pc_bits;
    assign unused_up_pc_bits = ^{bus.up_pc[1:0], bus.up_pc[DBITS-1:IDXBITS+TAGBITS+2]};

    // Lookup reads current table state only; an update in the same cycle is not bypassed.
    assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken      = lk_hit && ctr_q[lk_idx][CNTBITS-1];
    assign bus.lk_hit    = lk_hit;
    assign bus.lk_taken  = lk_taken;
    assign bus.lk_predpc = lk_taken ? target_q[lk_idx] : bus.lk_pc + DBITS'(INSTSIZE);

    assign up_hit          = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign bus.upd_cnt     = upd_cnt_q;
    assign bus.mispred_cnt = mispred_cnt_q;

    always_comb begin
        valid_d       = valid_q;
        tag_d         = tag_q;
        target_d      = target_q;
        ctr_d         = ctr_q;
        upd_cnt_d     = upd_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        if (bus.up_valid && bus.up_mispred) begin
            mispred_cnt_d = mispred_cnt_q + DBITS'(1);
        end

        // Flush only clears valid bits and swallows any concurrent update.
        if (bus.flush) begin
            valid_d = '0;
        end else if (bus.up_valid) begin
            upd_cnt_d = upd_cnt_q + DBITS'(1);
            if (bus.up_taken) begin
                target_d[up_idx] = bus.up_target;
                if (up_hit) begin
                    if (ctr_q[up_idx] != CTR_MAX) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + CNTBITS'(1);
                    end
                end else begin
                    valid_d[up_idx] = 1'b1;
                    tag_d[up_idx]   = up_tag;
                    ctr_d[up_idx]   = CTR_WT;
                end
            end else if (up_hit && (ctr_q[up_idx] != '0)) begin
                ctr_d[up_idx] = ctr_q[up_idx] - CNTBITS'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q       <= '0;
            upd_cnt_q     <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else begin
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            target_q      <= target_d;
            ctr_q         <= ctr_d;
            upd_cnt_q     <= upd_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - directed vector bench for branch_target_predictor
module tb_branch_target_predictor;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    branch_target_predictor_if #(.DBITS(32)) bus ();

    branch_target_predictor #(
        .DBITS(32), .INSTSIZE(4), .IDXBITS(8), .TAGBITS(8), .CNTBITS(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        upv;
        logic [31:0] up_pc;
        logic        up_taken;
        logic [31:0] up_target;
        logic        up_mis;
        logic        flush;
        logic [31:0] lk_pc;
        logic        exp_hit;
        logic        exp_taken;
        logic [31:0] exp_pred;
        logic [31:0] exp_upd;
        logic [31:0] exp_mis;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_lookup(input string tag, input logic hit, input logic tk, input logic [31:0] pred);
        check({tag, " lk_hit"}, 32'(bus.lk_hit), 32'(hit));
        check({tag, " lk_taken"}, 32'(bus.lk_taken), 32'(tk));
        check({tag, " lk_predpc"}, bus.lk_predpc, pred);
    endtask

    task automatic drive_update(input logic v, input logic [31:0] pc, input logic tk,
                                input logic [31:0] tgt, input logic mis, input logic fl);
        bus.up_valid   = v;
        bus.up_pc      = pc;
        bus.up_taken   = tk;
        bus.up_target  = tgt;
        bus.up_mispred = mis;
        bus.flush      = fl;
    endtask

    task automatic idle_inputs();
        drive_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        //           upv  up_pc      tk   target     mis  fl   lk_pc        hit  tk   pred         upd mis
        vecs[0]  = '{1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 32'h100,      1'b0, 1'b0, 32'h104,      0,  0};
        vecs[1]  = '{1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0,        0,  0};
        vecs[2]  = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b0, 32'h100,      1'b1, 1'b1, 32'h200,      1,  1};
        vecs[3]  = '{1'b1, 32'h100, 1'b0, 32'h000, 1'b0, 1'b0, 32'h100,      1'b1, 1'b0, 32'h104,      2,  1};
        vecs[4]  = '{1'b1, 32'h100, 1'b0, 32'h000, 1'b0, 1'b0, 32'h100,      1'b1, 1'b0, 32'h104,      3,  1};
        vecs[5]  = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h100,      1'b1, 1'b0, 32'h104,      4,  1};
        vecs[6]  = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h100,      1'b1, 1'b1, 32'h200,      5,  1};
        vecs[7]  = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h100,      1'b1, 1'b1, 32'h200,      6,  1};
        vecs[8]  = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h100,      1'b1, 1'b1, 32'h200,      7,  1};
        vecs[9]  = '{1'b1, 32'h100, 1'b0, 32'h000, 1'b0, 1'b0, 32'h100,      1'b1, 1'b1, 32'h200,      8,  1};
        vecs[10] = '{1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 32'h500,      1'b0, 1'b0, 32'h504,      8,  1};
        vecs[11] = '{1'b1, 32'h500, 1'b0, 32'h000, 1'b1, 1'b0, 32'h100,      1'b1, 1'b1, 32'h200,      9,  2};
        vecs[12] = '{1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 32'h500,      1'b0, 1'b0, 32'h504,      9,  2};
        vecs[13] = '{1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 1'b0, 32'h500,      1'b1, 1'b1, 32'h600,      10, 2};
        vecs[14] = '{1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 32'h100,      1'b0, 1'b0, 32'h104,      10, 2};

        reset     = 1'b1;
        bus.lk_pc = 32'h100;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_lookup("in_reset", 1'b0, 1'b0, 32'h104);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive_update(vecs[i].upv, vecs[i].up_pc, vecs[i].up_taken, vecs[i].up_target,
                         vecs[i].up_mis, vecs[i].flush);
            @(posedge clk);
            #1;
            idle_inputs();
            bus.lk_pc = vecs[i].lk_pc;
            #1;
            check_lookup($sformatf("vec%0d", i), vecs[i].exp_hit, vecs[i].exp_taken, vecs[i].exp_pred);
            check($sformatf("vec%0d upd_cnt", i), bus.upd_cnt, vecs[i].exp_upd);
            check($sformatf("vec%0d mispred_cnt", i), bus.mispred_cnt, vecs[i].exp_mis);
        end

        // Reallocate 0x100 (evicts 0x500), then retarget it while looking it up in the same cycle.
        drive_update(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive_update(1'b1, 32'h100, 1'b1, 32'h300, 1'b0, 1'b0);
        bus.lk_pc = 32'h100;
        #1;
        check_lookup("same_cycle_old", 1'b1, 1'b1, 32'h200);
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check_lookup("same_cycle_new", 1'b1, 1'b1, 32'h300);
        check("same_cycle upd_cnt", bus.upd_cnt, 32'd12);

        // Flush together with a mispredicted update: update dropped, mispredict still counted.
        drive_update(1'b1, 32'h100, 1'b1, 32'h700, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        idle_inputs();
        bus.lk_pc = 32'h100;
        #1;
        check_lookup("flush 0x100", 1'b0, 1'b0, 32'h104);
        bus.lk_pc = 32'h500;
        #1;
        check_lookup("flush 0x500", 1'b0, 1'b0, 32'h504);
        check("flush upd_cnt", bus.upd_cnt, 32'd12);
        check("flush mispred_cnt", bus.mispred_cnt, 32'd3);

        // Counter survives flush: a taken update on a miss allocates weakly taken (ctr=2).
        drive_update(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        idle_inputs();
        bus.lk_pc = 32'h100;
        #1;
        check_lookup("realloc", 1'b1, 1'b1, 32'h200);

        // Asynchronous reset between edges with an update in flight.
        #2;
        drive_update(1'b1, 32'h100, 1'b1, 32'h900, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        check_lookup("async_reset", 1'b0, 1'b0, 32'h104);
        check("async_reset upd_cnt", bus.upd_cnt, 32'd0);
        check("async_reset mispred_cnt", bus.mispred_cnt, 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        bus.lk_pc = 32'h100;
        #1;
        check_lookup("post_reset", 1'b0, 1'b0, 32'h104);
        check("post_reset upd_cnt", bus.upd_cnt, 32'd0);
        check("post_reset mispred_cnt", bus.mispred_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
